// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory round-robin arbiter.
// Optional statistics are enabled with DMEM_ARB_STATS_EN.
package dmem_arb_pkg;
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPT
    } state_t;

    localparam int STAT_W     = 16;
    localparam int DEF_WIDTH  = 16;
    localparam int DEF_NCORES = 8;
endpackage

// File: rtl/dmem_rr_arbiter_if.sv
// Core-array and data-memory bus seen by the arbiter.
// Slave is the arbiter side; master is the cores plus memory.
interface dmem_rr_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NCORES = DEF_NCORES
);
    logic [NCORES-1:0]       core_rd;
    logic [NCORES-1:0]       core_wr;
    logic [NCORES*WIDTH-1:0] core_addr;
    logic [NCORES*WIDTH-1:0] core_wdata;
    logic [NCORES*WIDTH-1:0] core_rdata;
    logic [NCORES-1:0]       core_av;
    logic                    mem_rEn;
    logic                    mem_wEn;
    logic [WIDTH-1:0]        mem_addr;
    logic [WIDTH-1:0]        mem_wdata;
    logic [WIDTH-1:0]        mem_rdata;
    logic                    busy;

    modport slave (
        input  core_rd, core_wr, core_addr, core_wdata, mem_rdata,
        output core_rdata, core_av, mem_rEn, mem_wEn,
        output mem_addr, mem_wdata, busy
    );

    modport master (
        output core_rd, core_wr, core_addr, core_wdata, mem_rdata,
        input  core_rdata, core_av, mem_rEn, mem_wEn,
        input  mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/dmem_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after ptr,
// wrapping modulo NCORES.
module rr_pick
    import dmem_arb_pkg::*;
#(
    parameter int  NCORES = DEF_NCORES,
    localparam int CW     = $clog2(NCORES)
) (
    input  logic [NCORES-1:0] req,
    input  logic [CW-1:0]     ptr,
    output logic              any_valid,
    output logic [CW-1:0]     grant
);
    logic [CW-1:0] cand;

    // Walk from farthest to nearest so the nearest hit wins.
    always_comb begin
        any_valid = 1'b0;
        grant     = '0;
        cand      = '0;
        for (int k = NCORES; k >= 1; k--) begin
            cand = CW'((int'(ptr) + k) % NCORES);
            if (req[cand]) begin
                any_valid = 1'b1;
                grant     = cand;
            end
        end
    end
endmodule

// File: rtl/dmem_rr_arbiter.sv
// Serializes per-core read/write requests onto one synchronous memory port.
// DMEM_ARB_STATS_EN adds per-core grant counters and a proto_err flag.
module dmem_rr_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int  WIDTH  = DEF_WIDTH,
    parameter int  NCORES = DEF_NCORES,
    localparam int CW     = $clog2(NCORES)
) (
    input  logic              Clk,
    input  logic              rst,
`ifdef DMEM_ARB_STATS_EN
    input  logic [CW-1:0]     stat_sel,
    output logic [STAT_W-1:0] stat_cnt,
    output logic              proto_err,
`endif
    dmem_rr_arbiter_if.slave  bus
);
    state_t            state_q, state_d;
    logic [CW-1:0]     g_q, g_d;
    logic [CW-1:0]     ptr_q, ptr_d;
    logic              wr_q, wr_d;
    logic [NCORES-1:0] av_q, av_d;
    logic [WIDTH-1:0]  rdata_q [NCORES];
    logic [WIDTH-1:0]  rdata_d [NCORES];
    logic [WIDTH-1:0]  addr_a  [NCORES];
    logic [WIDTH-1:0]  wdata_a [NCORES];
    logic [NCORES-1:0] req;
    logic              pick_any;
    logic [CW-1:0]     pick_idx;
    logic              mem_ren, mem_wen;
    logic [WIDTH-1:0]  mem_addr, mem_wdata;

    for (genvar i = 0; i < NCORES; i++) begin : g_core
        assign addr_a[i]  = bus.core_addr[i*WIDTH +: WIDTH];
        assign wdata_a[i] = bus.core_wdata[i*WIDTH +: WIDTH];
        assign bus.core_rdata[i*WIDTH +: WIDTH] = rdata_q[i];
    end

    // A core still sees its completion pulse this cycle; never re-grant it.
    assign req = (bus.core_rd | bus.core_wr) & ~av_q;

    rr_pick #(.NCORES(NCORES)) u_pick (
        .req       (req),
        .ptr       (ptr_q),
        .any_valid (pick_any),
        .grant     (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        g_d       = g_q;
        wr_d      = wr_q;
        ptr_d     = ptr_q;
        av_d      = '0;
        rdata_d   = rdata_q;
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    g_d     = pick_idx;
                    wr_d    = bus.core_wr[pick_idx];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                mem_addr = addr_a[g_q];
                if (wr_q) begin
                    mem_wen   = 1'b1;
                    mem_wdata = wdata_a[g_q];
                end else begin
                    mem_ren = 1'b1;
                end
                state_d = CAPT;
            end
            CAPT: begin
                if (!wr_q) rdata_d[g_q] = bus.mem_rdata;
                av_d[g_q] = 1'b1;
                ptr_d     = g_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            g_q     <= '0;
            wr_q    <= 1'b0;
            ptr_q   <= CW'(NCORES - 1);
            av_q    <= '0;
            rdata_q <= '{default: '0};
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            wr_q    <= wr_d;
            ptr_q   <= ptr_d;
            av_q    <= av_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.core_av   = av_q;
    assign bus.mem_rEn   = mem_ren;
    assign bus.mem_wEn   = mem_wen;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.busy      = (state_q != IDLE);

`ifdef DMEM_ARB_STATS_EN
    logic [STAT_W-1:0] cnt_q [NCORES];
    logic [STAT_W-1:0] cnt_d [NCORES];
    logic              proto_q, proto_d;

    always_comb begin
        cnt_d   = cnt_q;
        proto_d = proto_q;
        if (state_q == IDLE && pick_any &&
            bus.core_rd[pick_idx] && bus.core_wr[pick_idx])
            proto_d = 1'b1;
        if (state_q == CAPT && cnt_q[g_q] != '1)
            cnt_d[g_q] = cnt_q[g_q] + STAT_W'(1);
    end

    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '{default: '0};
            proto_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            proto_q <= proto_d;
        end
    end

    assign stat_cnt  = cnt_q[stat_sel];
    assign proto_err = proto_q;
`endif
endmodule

// File: tb/tb_dmem_rr_arbiter.sv
// Scoreboard bench for dmem_rr_arbiter: stimulus pushes expected memory
// strobes and completions, a negedge monitor pops and compares them.
module tb_dmem_rr_arbiter;
    import dmem_arb_pkg::*;

    localparam int W = 16;
    localparam int N = 8;

    logic Clk = 1'b0;
    logic rst = 1'b1;
    always #5 Clk = ~Clk;

    dmem_rr_arbiter_if #(.WIDTH(W), .NCORES(N)) bus ();

`ifdef DMEM_ARB_STATS_EN
    logic [2:0]  stat_sel  = 3'd0;
    logic [15:0] stat_cnt;
    logic        proto_err;
    bit          chk_stat  = 1'b0;
    logic [15:0] exp_cnt   = '0;
    logic        exp_proto = 1'b0;
`endif

    dmem_rr_arbiter #(.WIDTH(W), .NCORES(N)) dut (
        .Clk       (Clk),
        .rst       (rst),
`ifdef DMEM_ARB_STATS_EN
        .stat_sel  (stat_sel),
        .stat_cnt  (stat_cnt),
        .proto_err (proto_err),
`endif
        .bus       (bus)
    );

    logic [N-1:0] t_rd = '0;
    logic [N-1:0] t_wr = '0;
    logic [15:0]  t_addr  [N];
    logic [15:0]  t_wdata [N];
    logic [15:0]  o_rdata [N];

    assign bus.core_rd = t_rd;
    assign bus.core_wr = t_wr;
    for (genvar i = 0; i < N; i++) begin : g_c
        assign bus.core_addr[i*W +: W]  = t_addr[i];
        assign bus.core_wdata[i*W +: W] = t_wdata[i];
        assign o_rdata[i] = bus.core_rdata[i*W +: W];
    end

    // Memory model: unwritten words read as {a,a}, except 0x40 holds BEEF.
    logic [15:0]  mem [256];
    logic [255:0] mem_seen    = '0;
    logic [15:0]  mem_rdata_r = '0;

    function automatic logic [15:0] init_val(logic [7:0] a);
        return (a == 8'h40) ? 16'hBEEF : {a, a};
    endfunction

    always @(posedge Clk) begin
        if (bus.mem_wEn) begin
            mem[bus.mem_addr[7:0]]      <= bus.mem_wdata;
            mem_seen[bus.mem_addr[7:0]] <= 1'b1;
        end
        if (bus.mem_rEn)
            mem_rdata_r <= mem_seen[bus.mem_addr[7:0]] ?
                           mem[bus.mem_addr[7:0]] : init_val(bus.mem_addr[7:0]);
    end
    assign bus.mem_rdata = mem_rdata_r;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        int          core;
        logic [15:0] rdata;
    } av_t;

    typedef struct {
        int          cyc;
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wdata;
    } mt_t;

    av_t av_q[$];
    mt_t mt_q[$];
    av_t m_av;
    mt_t m_mt;

    int total = 0;
    int bad   = 0;
    bit done       = 1'b0;
    bit final_done = 1'b0;
    bit auto_drop  = 1'b1;

    always @(negedge Clk) begin
        if (rst) begin
            total++;
            if (bus.busy || bus.core_av != '0 || bus.mem_rEn || bus.mem_wEn ||
                bus.mem_addr != '0 || bus.mem_wdata != '0 || bus.core_rdata != '0) begin
                bad++;
                $display("FAIL reset_state cyc=%0d busy=%b av=%b ren=%b wen=%b addr=%h wdata=%h rdata=%h required all 0",
                         cyc, bus.busy, bus.core_av, bus.mem_rEn, bus.mem_wEn,
                         bus.mem_addr, bus.mem_wdata, bus.core_rdata);
            end
        end else begin
            if (bus.mem_rEn || bus.mem_wEn) begin
                total++;
                if (mt_q.size() == 0) begin
                    bad++;
                    $display("FAIL mem_strobe cyc=%0d ren=%b wen=%b addr=%h required no strobe",
                             cyc, bus.mem_rEn, bus.mem_wEn, bus.mem_addr);
                end else begin
                    m_mt = mt_q.pop_front();
                    if (cyc != m_mt.cyc || bus.mem_wEn != m_mt.wr ||
                        bus.mem_rEn == m_mt.wr || bus.mem_addr != m_mt.addr ||
                        bus.mem_wdata != (m_mt.wr ? m_mt.wdata : 16'h0)) begin
                        bad++;
                        $display("FAIL mem_strobe cyc=%0d wen=%b ren=%b addr=%h wdata=%h required cyc=%0d wr=%b addr=%h wdata=%h",
                                 cyc, bus.mem_wEn, bus.mem_rEn, bus.mem_addr, bus.mem_wdata,
                                 m_mt.cyc, m_mt.wr, m_mt.addr, m_mt.wr ? m_mt.wdata : 16'h0);
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                if (bus.core_av[i[2:0]]) begin
                    total++;
                    if (av_q.size() == 0) begin
                        bad++;
                        $display("FAIL core_av cyc=%0d core=%0d required no completion", cyc, i);
                    end else begin
                        m_av = av_q.pop_front();
                        if (m_av.core != i || m_av.cyc != cyc || o_rdata[i[2:0]] != m_av.rdata) begin
                            bad++;
                            $display("FAIL core_av cyc=%0d core=%0d rdata=%h required cyc=%0d core=%0d rdata=%h",
                                     cyc, i, o_rdata[i[2:0]], m_av.cyc, m_av.core, m_av.rdata);
                        end
                    end
                end
            end
`ifdef DMEM_ARB_STATS_EN
            if (chk_stat) begin
                total++;
                if (proto_err != exp_proto || stat_cnt != exp_cnt) begin
                    bad++;
                    $display("FAIL stats cyc=%0d sel=%0d proto=%b cnt=%0d required proto=%b cnt=%0d",
                             cyc, stat_sel, proto_err, stat_cnt, exp_proto, exp_cnt);
                end
            end
`endif
        end
        if (done && !final_done) begin
            total++;
            if (av_q.size() != 0 || mt_q.size() != 0) begin
                bad++;
                $display("FAIL drain pending_av=%0d pending_mem=%0d required 0 and 0",
                         av_q.size(), mt_q.size());
            end
            final_done = 1'b1;
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
        if (auto_drop) begin
            t_rd = t_rd & ~bus.core_av;
            t_wr = t_wr & ~bus.core_av;
        end
    endtask

    task automatic raise(logic [2:0] c, bit rd, bit wr,
                         logic [15:0] a, logic [15:0] d);
        t_addr[c]  = a;
        t_wdata[c] = d;
        if (rd) t_rd[c] = 1'b1;
        if (wr) t_wr[c] = 1'b1;
    endtask

    // c0 is the IDLE cycle in which the grant decision is made.
    task automatic expect_txn(int c0, int core, bit wr, logic [15:0] a,
                              logic [15:0] d, logic [15:0] rdata);
        mt_q.push_back('{c0 + 1, wr, a, d});
        av_q.push_back('{c0 + 3, core, rdata});
    endtask

    int c;

    initial begin
        for (int i = 0; i < N; i++) begin
            t_addr[i]  = '0;
            t_wdata[i] = '0;
        end
        repeat (3) @(posedge Clk);
        #1 rst = 1'b0;
        repeat (2) tick();

        c = cyc;
        raise(3'd3, 1'b1, 1'b0, 16'h0040, 16'h0);
        expect_txn(c, 3, 1'b0, 16'h0040, 16'h0, 16'hBEEF);
        repeat (5) tick();

        c = cyc;
        raise(3'd5, 1'b0, 1'b1, 16'h0090, 16'h1234);
        expect_txn(c, 5, 1'b1, 16'h0090, 16'h1234, 16'h0000);
        repeat (5) tick();
        c = cyc;
        raise(3'd5, 1'b1, 1'b0, 16'h0090, 16'h0);
        expect_txn(c, 5, 1'b0, 16'h0090, 16'h0, 16'h1234);
        repeat (5) tick();

        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        c = cyc;
        for (int i = 0; i < N; i++) begin
            raise(i[2:0], 1'b1, 1'b0, 16'(16 + i), 16'h0);
            expect_txn(c + 3 * i, i, 1'b0, 16'(16 + i), 16'h0,
                       16'(16'h1010 + 16'h0101 * i));
        end
        repeat (3 * N + 3) tick();

        c = cyc;
        raise(3'd6, 1'b1, 1'b0, 16'h0066, 16'h0);
        expect_txn(c, 6, 1'b0, 16'h0066, 16'h0, 16'h6666);
        repeat (5) tick();

        auto_drop = 1'b0;
        c = cyc;
        raise(3'd2, 1'b1, 1'b0, 16'h0022, 16'h0);
        raise(3'd6, 1'b1, 1'b0, 16'h0066, 16'h0);
        expect_txn(c,     2, 1'b0, 16'h0022, 16'h0, 16'h2222);
        expect_txn(c + 3, 6, 1'b0, 16'h0066, 16'h0, 16'h6666);
        expect_txn(c + 6, 2, 1'b0, 16'h0022, 16'h0, 16'h2222);
        expect_txn(c + 9, 6, 1'b0, 16'h0066, 16'h0, 16'h6666);
        repeat (12) tick();
        t_rd = '0;
        t_wr = '0;
        auto_drop = 1'b1;
        repeat (4) tick();

        c = cyc;
        raise(3'd1, 1'b1, 1'b0, 16'h0031, 16'h0);
        tick();
        rst = 1'b1;
        raise(3'd0, 1'b1, 1'b0, 16'h0030, 16'h0);
        repeat (2) tick();
        rst = 1'b0;
        c = cyc;
        expect_txn(c,     0, 1'b0, 16'h0030, 16'h0, 16'h3030);
        expect_txn(c + 3, 1, 1'b0, 16'h0031, 16'h0, 16'h3131);
        repeat (8) tick();

`ifdef DMEM_ARB_STATS_EN
        stat_sel  = 3'd0;
        exp_cnt   = 16'd1;
        exp_proto = 1'b0;
        chk_stat  = 1'b1;
        tick();
        stat_sel  = 3'd4;
        exp_cnt   = 16'd0;
        tick();
        chk_stat  = 1'b0;
        c = cyc;
        raise(3'd4, 1'b1, 1'b1, 16'h0044, 16'h4444);
        expect_txn(c, 4, 1'b1, 16'h0044, 16'h4444, 16'h0000);
        tick();
        exp_proto = 1'b1;
        exp_cnt   = 16'd0;
        chk_stat  = 1'b1;
        repeat (2) tick();
        exp_cnt   = 16'd1;
        repeat (3) tick();
        chk_stat  = 1'b0;
`endif

        done = 1'b1;
        @(negedge Clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmem_rr_arbiter.md
# dmem_rr_arbiter

Responder side of the core-to-data-memory request protocol: accepts read/write requests from NCORES cores and serializes them onto the single-port synchronous data memory. It uses round-robin fairness and returns a one-cycle completion pulse per core. It sits between the core array and the data memory, in the processor top, next to the instruction-memory controller.

## Interface
- WIDTH, 16, data and address width
- NCORES, 8, number of requesting cores (≥2)
- CW, $clog2(NCORES), core index width (derived, not overridable)

- Clk  in  1  system clock; everything is rising-edge
- rst  in  1  asynchronous, active-high reset
- core_rd  in  NCORES  per-core read request level
- core_wr  in  NCORES  per-core write request level
- core_addr  in  NCORES*WIDTH  per-core address; slice i = core i
- core_wdata  in  NCORES*WIDTH  per-core write data
- core_rdata  out  NCORES*WIDTH  per-core registered read data
- core_av  out  NCORES  per-core completion pulse (one cycle)
- mem_rEn  out  1  memory read strobe
- mem_wEn  out  1  memory write strobe
- mem_addr  out  WIDTH  memory address
- mem_wdata  out  WIDTH  memory write data
- mem_rdata  in  WIDTH  memory read data, valid the cycle after mem_rEn
- busy  out  1  high whenever state ≠ IDLE

## Operation
- Request protocol:
  - A core raises core_rd or core_wr and holds the request, core_addr and core_wdata stable until it sees core_av[i]=1.
  - It must drop the request in the cycle core_av[i] is high.
  - core_rd and core_wr both high on one core: serviced as a write.
- FSM states: IDLE, ISSUE, CAPT.
  - IDLE: form the request vector (core_rd|core_wr) masked by core_av. If any bit is set, pick a winner with the round-robin picker, latch grant index g, latch kind (write if core_wr[g]), and go to ISSUE.
  - ISSUE: drive mem_addr=core_addr[g]. A write drives mem_wEn=1 and mem_wdata=core_wdata[g]. A read drives mem_rEn=1. Go to CAPT.
  - CAPT: for a read, register mem_rdata into core_rdata[g]. Set core_av[g]=1 for the next cycle only, update ptr=g, and go to IDLE.
- Round-robin: search starts at ptr+1 and wraps modulo NCORES. ptr resets to NCORES-1, so core 0 wins first after reset.
- core_rdata[i] holds its last read value and is untouched by writes or by other cores' reads.
- Memory strobes and mem_addr/mem_wdata are combinational from the state and latched g. They are 0 outside ISSUE.

## Timing
- Request first visible in IDLE cycle c:
  - mem strobe during c+1
  - mem_rdata valid during c+2
  - core_av and core_rdata valid during c+3
  - Next grant decision is made in cycle c+3, with the completing core masked.
- Throughput: one transaction per 3 cycles with back-to-back requests.
- Reset values:
  - core_rdata = 0, core_av = 0, busy = 0, all mem_* = 0
  - state = IDLE, ptr = NCORES-1
- Reset mid-transaction aborts the transaction with no core_av pulse. A write already strobed in ISSUE may have completed in memory.
- A request withdrawn before grant is ignored; withdrawing after grant is a protocol violation with undefined data.
- A request arriving during ISSUE/CAPT waits for the next IDLE.

## Configuration
- DMEM_ARB_STATS_EN defined:
  - Adds one 16-bit saturating grant counter per core, incremented in CAPT for g; it stops at 16'hFFFF.
  - Adds a sticky proto_err flag, set when a core presents rd and wr together at grant.
  - Adds ports stat_sel (in, CW), stat_cnt (out, 16, combinational read of counter[stat_sel]) and proto_err (out, 1).
  - All of these reset to 0.
- Undefined: counters, flag and the three ports are absent; the functional behaviour above is unchanged.

## Structure
- Shared package dmem_arb_pkg holds:
  - the state enum (IDLE, ISSUE, CAPT)
  - the STAT_W=16 constant
  - localparam defaults for WIDTH and NCORES
- Sub-module rr_pick (combinational):
  - inputs: req vector and ptr
  - outputs: any-valid and grant index

## Test plan
- Reset, then core 3 reads 0x0040 (memory holds 0xBEEF) -> mem_rEn one cycle, core_av[3] three cycles after request, core_rdata[3]=0xBEEF.
- Core 5 writes 0x1234 to 0x0090, then reads it back -> mem_wEn one cycle with those values; the read returns 0x1234; core_rdata[5] is unchanged by the write.
- All 8 cores request reads simultaneously after reset -> grants in order 0,1,…,7, each core_av 3 cycles apart, no core served twice.
- Cores 2 and 6 request continuously while ptr=6 -> alternating grants 2,6,2,6; each core is masked in its core_av cycle.
- Assert rst during ISSUE of a read by core 1 -> all outputs 0 immediately, no core_av[1]; after release the re-held request is served with core 0 priority.
- With DMEM_ARB_STATS_EN, core 4 asserts rd and wr together -> a write occurs, proto_err=1 (sticky), and stat_sel=4 gives stat_cnt=1.
